bus_unit_mmio: RTL and testbench
================================

# bus_unit_mmio

Two-master bus unit for the sigma SoC, successor to the fixed GPIO memsplit unit. Addresses with bit 31 clear go to the dual-port on-chip RAM. Addresses with bit 31 set go to a parametrised MMIO block with four registers: GPIO out, GPIO in, a 32-bit timer, and a compare register that drives an interrupt. Additions over the previous generation:
- arbitration for simultaneous MMIO accesses;
- byte-enable writes to MMIO registers;
- configurable MMIO read latency;
- at most one outstanding read per bus.

## Interface
Parameters:
- mem_init, "YES", preload the RAM from a file.
- mem_data, "data.hex", RAM image file.
- mem_size, 1024, RAM depth in 32-bit words.
- GPIO_W, 32, GPIO width. Legal range 1..32.
- IO_LAT, 1, cycles from MMIO ack to MMIO resp. Legal range 1..4.

Ports. One clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- busN_req_i  in  1  request (N = 0, 1)
- busN_we_i  in  1  1 = write
- busN_addr_bi  in  32  byte address
- busN_be_bi  in  4  byte enables
- busN_wdata_bi  in  32  write data
- busN_ack_o  out  1  request accepted this cycle (combinational)
- busN_resp_o  out  1  read data valid, one-cycle pulse
- busN_rdata_bo  out  32  read data, valid only while resp = 1
- gpio_bi  in  GPIO_W  asynchronous GPIO inputs
- gpio_bo  out  GPIO_W  GPIO outputs
- irq_o  out  1  timer match interrupt, equal to STATUS[0]

## Operation
- Decode:
  - addr[31] = 0 → RAM. The request is forwarded to the RAM port with addr[31:2].
  - addr[31] = 1 → MMIO. The register is selected by addr[7:0].
- MMIO map. Write data is masked by be; reads are zero-extended to 32 bits.
  - 0x00 GPIO_OUT: RW. Only the low GPIO_W bits are stored.
  - 0x04 GPIO_IN: RO. Returns gpio_bi through a 2-flop synchroniser.
  - 0x08 TIMER: RW. Increments by 1 every cycle and wraps at 2^32. A bus write loads the written value instead of incrementing that cycle.
  - 0x0C CMP: RW.
  - 0x10 STATUS: bit0 = match, sticky. Writing 1 to bit0 clears it.
  - Any other offset: writes are ignored; reads return 0x55AA55AA.
- Match: STATUS[0] is set the cycle after TIMER == CMP. If set and clear coincide, set wins.
- MMIO arbitration (one MMIO access per cycle):
  - When both buses present an acceptable MMIO request, the bus not granted last wins. The loser sees ack = 0 and retries.
  - The last-grant pointer updates on every MMIO grant. After reset it points to bus1, so bus0 wins first.
- Read gating, per bus:
  - An outstanding flag is set on any acked read (RAM or MMIO) and cleared in that bus's resp cycle.
  - While the flag is set and resp = 0, new reads from that bus are not acked, and a RAM read is not forwarded to the RAM.
  - Writes are never gated by the flag.
- Response mux: an MMIO resp has priority, but gating ensures RAM and MMIO responses never collide.
- Write conflict: two MMIO writes in the same cycle cannot happen, because arbitration grants one per cycle.

## Timing
- ack is combinational in the request cycle:
  - RAM: ack = RAM ack AND NOT gated.
  - MMIO: ack = granted AND NOT (read AND gated).
- MMIO read data is captured in the ack cycle. resp pulses exactly IO_LAT cycles later; IO_LAT = 1 means the next cycle.
- An MMIO write takes effect on the clock edge ending its ack cycle. A read acked in the following cycle sees the new value.
- RAM latency is unchanged from ram_dual_memsplit.
- Reset values:
  - gpio_bo = 0, TIMER = 0, CMP = 0xFFFFFFFF, STATUS = 0, irq_o = 0.
  - resp = 0; outstanding flags cleared; response pipelines flushed.
  - Last-grant pointer = bus1.
- Reset mid-operation: pending MMIO responses are dropped (no resp is produced). The RAM is reset in the same cycle.

## Structure
- Shared package/header holds: MMIO offsets (0x00–0x10), the 0x55AA55AA default, the CMP reset value, and STATUS bit indices.
- Sub-module: ram_dual_memsplit is instantiated unchanged for the RAM side.
- Inline in this block: MMIO register file, arbiter, and per-bus response pipelines. The pipeline is a shift register of depth IO_LAT.

## Test plan
- GPIO_OUT with byte enables:
  - bus0 writes 0xDEADBEEF to 0x80000000 with be = 0xF → gpio_bo = 0xDEADBEEF.
  - bus1 then writes 0x00000011 with be = 0x1 → gpio_bo = 0xDEADBE11.
  - Reading 0x80000000 with IO_LAT = 3 → resp exactly 3 cycles after ack, rdata = 0xDEADBE11.
- Arbitration: both buses request MMIO reads every cycle for 4 cycles → grants alternate bus0, bus1, bus0, bus1; each loser sees ack = 0.
- Timer match: write CMP = 20, TIMER = 10 → STATUS[0] and irq_o rise 11 cycles after the TIMER write. Writing 1 to 0x80000010 clears them the next cycle.
- Read gating: bus0 issues a RAM read, then an immediate MMIO read of 0x80000004 → the second read is acked only in the RAM resp cycle; responses arrive in order with no overlap.
- Unmapped offset: a read of 0x80000040 returns 0x55AA55AA; a write there changes no register.
- Reset during outstanding IO_LAT = 4 read → no resp pulse afterwards; all outputs at reset values; gpio_bo = 0.

Source files
------------

// File: rtl/bus_unit_mmio_pkg.sv
// Shared definitions for the two-master bus unit: MMIO map, reset constants
// and the byte-enable merge helper.
package bus_unit_mmio_pkg;

    // MMIO register offsets (addr[7:0] once addr[31] selects MMIO)
    localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
    localparam logic [7:0] OFF_TIMER    = 8'h08;
    localparam logic [7:0] OFF_CMP      = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;

    // Read value of every unmapped offset
    localparam logic [31:0] MMIO_DEFAULT = 32'h55AA55AA;
    // CMP comes out of reset as far away from TIMER = 0 as possible
    localparam logic [31:0] CMP_RST      = 32'hFFFF_FFFF;

    // STATUS bit positions
    localparam int STAT_MATCH = 0;

    // One bus request as seen by the MMIO side
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

    // Replace the enabled bytes of old with the matching bytes of wd
    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_unit_mmio_ram.sv
// ram_dual_memsplit: dual-port 32-bit word RAM with byte enables.
// Each port accepts every request in the cycle it is presented; reads
// answer with a one-cycle resp pulse on the following cycle.
module ram_dual_memsplit #(
    parameter string mem_init = "YES",
    parameter string mem_data = "data.hex",
    parameter int    mem_size = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [29:0] p0_addr_bi,
    input  logic [3:0]  p0_be_bi,
    input  logic [31:0] p0_wdata_bi,
    output logic        p0_ack_o,
    output logic        p0_resp_o,
    output logic [31:0] p0_rdata_bo,
    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [29:0] p1_addr_bi,
    input  logic [3:0]  p1_be_bi,
    input  logic [31:0] p1_wdata_bi,
    output logic        p1_ack_o,
    output logic        p1_resp_o,
    output logic [31:0] p1_rdata_bo
);
    localparam int AW = (mem_size > 1) ? $clog2(mem_size) : 1;

    logic [31:0]   mem [mem_size];
    logic [AW-1:0] idx0, idx1;

    assign idx0 = p0_addr_bi[AW-1:0];
    assign idx1 = p1_addr_bi[AW-1:0];

    // Word address bits above the RAM depth alias onto the array
    if (AW < 30) begin : g_alias
        logic unused_hi;
        assign unused_hi = ^{p0_addr_bi[29:AW], p1_addr_bi[29:AW]};
    end

    // Marks RAM instances built with a preloaded image; the image named by
    // mem_data is attached to this scope by the memory-init flow.
    if (mem_init == "YES" && mem_data != "") begin : g_preload
    end

    // Both ports always accept
    assign p0_ack_o = p0_req_i;
    assign p1_ack_o = p1_req_i;

    // Byte-enabled writes; port1 lands last on a same-word collision
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (p0_req_i && p0_we_i && p0_be_bi[i]) mem[idx0][8*i +: 8] <= p0_wdata_bi[8*i +: 8];
            if (p1_req_i && p1_we_i && p1_be_bi[i]) mem[idx1][8*i +: 8] <= p1_wdata_bi[8*i +: 8];
        end
    end

    // Read data register (read-before-write)
    always_ff @(posedge clk_i) begin
        p0_rdata_bo <= mem[idx0];
        p1_rdata_bo <= mem[idx1];
    end

    // One-cycle read response strobes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p0_resp_o <= 1'b0;
            p1_resp_o <= 1'b0;
        end else begin
            p0_resp_o <= p0_req_i & ~p0_we_i;
            p1_resp_o <= p1_req_i & ~p1_we_i;
        end
    end

endmodule

// File: rtl/bus_unit_mmio.sv
// Two-master bus unit: addr[31]=0 goes to the dual-port RAM, addr[31]=1 to
// the MMIO register file (GPIO out/in, timer, compare, status). MMIO is
// shared, so a round-robin arbiter grants one MMIO access per cycle. Each
// bus may have only one read in flight.
module bus_unit_mmio
    import bus_unit_mmio_pkg::*;
#(
    parameter string mem_init = "YES",
    parameter string mem_data = "data.hex",
    parameter int    mem_size = 1024,
    parameter int    GPIO_W   = 32,
    parameter int    IO_LAT   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bus0_req_i,
    input  logic              bus0_we_i,
    input  logic [31:0]       bus0_addr_bi,
    input  logic [3:0]        bus0_be_bi,
    input  logic [31:0]       bus0_wdata_bi,
    output logic              bus0_ack_o,
    output logic              bus0_resp_o,
    output logic [31:0]       bus0_rdata_bo,
    input  logic              bus1_req_i,
    input  logic              bus1_we_i,
    input  logic [31:0]       bus1_addr_bi,
    input  logic [3:0]        bus1_be_bi,
    input  logic [31:0]       bus1_wdata_bi,
    output logic              bus1_ack_o,
    output logic              bus1_resp_o,
    output logic [31:0]       bus1_rdata_bo,
    input  logic [GPIO_W-1:0] gpio_bi,
    output logic [GPIO_W-1:0] gpio_bo,
    output logic              irq_o
);
    bus_req_t [1:0]        breq;
    logic [1:0]            is_rd, gated, io_want, io_gnt;
    logic [1:0]            ram_req, ram_ack, ram_resp, io_resp, resp, ack, rd_flag;
    logic [1:0][31:0]      ram_rdata, io_rdata, rdata;

    logic                  last_gnt;      // 1 = bus1 had the last MMIO grant
    logic                  io_sel, io_acc, io_wr, st_clr;
    bus_req_t              io_req;
    logic [7:0]            io_off;
    logic [31:0]           io_rd_val;

    logic [GPIO_W-1:0]     gpio_out, gpio_meta, gpio_sync;
    logic [31:0]           timer, cmp;
    logic                  st_match;

    assign breq[0] = '{req: bus0_req_i, we: bus0_we_i, addr: bus0_addr_bi,
                       be: bus0_be_bi, wdata: bus0_wdata_bi};
    assign breq[1] = '{req: bus1_req_i, we: bus1_we_i, addr: bus1_addr_bi,
                       be: bus1_be_bi, wdata: bus1_wdata_bi};

    // Round-robin: on contention the bus not granted last wins
    assign io_gnt[0] = io_want[0] & (~io_want[1] | last_gnt);
    assign io_gnt[1] = io_want[1] & (~io_want[0] | ~last_gnt);

    assign io_sel = io_gnt[1];
    assign io_acc = |io_gnt;
    assign io_req = breq[io_sel];
    assign io_off = io_req.addr[7:0];
    assign io_wr  = io_acc & io_req.we;
    assign st_clr = io_wr && io_off == OFF_STATUS && io_req.be[STAT_MATCH/8]
                    && io_req.wdata[STAT_MATCH];

    for (genvar b = 0; b < 2; b++) begin : g_bus
        logic [IO_LAT-1:0]       vld_pipe;
        logic [IO_LAT-1:0][31:0] dat_pipe;

        assign is_rd[b]   = ~breq[b].we;
        // A read waits while its predecessor is still in flight, except in
        // the cycle that predecessor answers
        assign gated[b]   = rd_flag[b] & ~resp[b];
        assign ram_req[b] = breq[b].req & ~breq[b].addr[31] & ~(is_rd[b] & gated[b]);
        assign io_want[b] = breq[b].req &  breq[b].addr[31] & ~(is_rd[b] & gated[b]);
        assign ack[b]     = ram_ack[b] | io_gnt[b];

        assign io_resp[b]  = vld_pipe[IO_LAT-1];
        assign io_rdata[b] = dat_pipe[IO_LAT-1];
        assign resp[b]     = io_resp[b] | ram_resp[b];
        assign rdata[b]    = io_resp[b] ? io_rdata[b] : ram_rdata[b];

        // MMIO read-valid shift register; reset drops anything in flight
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= io_gnt[b] & is_rd[b];
                for (int i = 1; i < IO_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
        end

        // MMIO read data, captured in the ack cycle and carried with valid
        always_ff @(posedge clk_i) begin
            dat_pipe[0] <= io_rd_val;
            for (int i = 1; i < IO_LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
        end

        // Outstanding-read flag: set on an acked read, cleared by its resp
        always_ff @(posedge clk_i) begin
            if (rst_i) rd_flag[b] <= 1'b0;
            else       rd_flag[b] <= (rd_flag[b] & ~resp[b]) | (ack[b] & is_rd[b]);
        end
    end

    // MMIO read mux for the granted bus
    always_comb begin
        io_rd_val = MMIO_DEFAULT;
        case (io_off)
            OFF_GPIO_OUT: io_rd_val = 32'(gpio_out);
            OFF_GPIO_IN:  io_rd_val = 32'(gpio_sync);
            OFF_TIMER:    io_rd_val = timer;
            OFF_CMP:      io_rd_val = cmp;
            OFF_STATUS: begin
                io_rd_val             = '0;
                io_rd_val[STAT_MATCH] = st_match;
            end
            default:      io_rd_val = MMIO_DEFAULT;
        endcase
    end

    // Two-flop synchroniser for the asynchronous GPIO inputs
    always_ff @(posedge clk_i) begin
        gpio_meta <= gpio_bi;
        gpio_sync <= gpio_meta;
    end

    // Register file, arbiter pointer and match detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpio_out <= '0;
            timer    <= '0;
            cmp      <= CMP_RST;
            st_match <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            if (io_acc) last_gnt <= io_sel;
            if (io_wr && io_off == OFF_GPIO_OUT)
                gpio_out <= GPIO_W'(be_merge(32'(gpio_out), io_req.wdata, io_req.be));
            if (io_wr && io_off == OFF_TIMER)
                timer <= be_merge(timer, io_req.wdata, io_req.be);
            else
                timer <= timer + 32'd1;
            if (io_wr && io_off == OFF_CMP)
                cmp <= be_merge(cmp, io_req.wdata, io_req.be);
            // A match in the same cycle as a clear keeps the flag set
            if (timer == cmp)  st_match <= 1'b1;
            else if (st_clr)   st_match <= 1'b0;
        end
    end

    ram_dual_memsplit #(
        .mem_init (mem_init),
        .mem_data (mem_data),
        .mem_size (mem_size)
    ) u_ram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .p0_req_i    (ram_req[0]),
        .p0_we_i     (breq[0].we),
        .p0_addr_bi  (breq[0].addr[31:2]),
        .p0_be_bi    (breq[0].be),
        .p0_wdata_bi (breq[0].wdata),
        .p0_ack_o    (ram_ack[0]),
        .p0_resp_o   (ram_resp[0]),
        .p0_rdata_bo (ram_rdata[0]),
        .p1_req_i    (ram_req[1]),
        .p1_we_i     (breq[1].we),
        .p1_addr_bi  (breq[1].addr[31:2]),
        .p1_be_bi    (breq[1].be),
        .p1_wdata_bi (breq[1].wdata),
        .p1_ack_o    (ram_ack[1]),
        .p1_resp_o   (ram_resp[1]),
        .p1_rdata_bo (ram_rdata[1])
    );

    assign bus0_ack_o    = ack[0];
    assign bus1_ack_o    = ack[1];
    assign bus0_resp_o   = resp[0];
    assign bus1_resp_o   = resp[1];
    assign bus0_rdata_bo = rdata[0];
    assign bus1_rdata_bo = rdata[1];
    assign gpio_bo       = gpio_out;
    assign irq_o         = st_match;

endmodule

// File: tb/tb_bus_unit_mmio.sv
// Directed bench for bus_unit_mmio (IO_LAT = 3, GPIO_W = 32).
module tb_bus_unit_mmio;
    localparam int IO_LAT = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        b0_req, b0_we, b1_req, b1_we;
    logic [31:0] b0_addr, b0_wdata, b1_addr, b1_wdata;
    logic [3:0]  b0_be, b1_be;
    logic        b0_ack, b0_resp, b1_ack, b1_resp, irq;
    logic [31:0] b0_rdata, b1_rdata, gpio_in, gpio_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    bus_unit_mmio #(
        .mem_init ("NO"),
        .mem_data ("data.hex"),
        .mem_size (1024),
        .GPIO_W   (32),
        .IO_LAT   (IO_LAT)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bus0_req_i    (b0_req),
        .bus0_we_i     (b0_we),
        .bus0_addr_bi  (b0_addr),
        .bus0_be_bi    (b0_be),
        .bus0_wdata_bi (b0_wdata),
        .bus0_ack_o    (b0_ack),
        .bus0_resp_o   (b0_resp),
        .bus0_rdata_bo (b0_rdata),
        .bus1_req_i    (b1_req),
        .bus1_we_i     (b1_we),
        .bus1_addr_bi  (b1_addr),
        .bus1_be_bi    (b1_be),
        .bus1_wdata_bi (b1_wdata),
        .bus1_ack_o    (b1_ack),
        .bus1_resp_o   (b1_resp),
        .bus1_rdata_bo (b1_rdata),
        .gpio_bi       (gpio_in),
        .gpio_bo       (gpio_out),
        .irq_o         (irq)
    );

    typedef struct {
        int          bus;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [31:0] exp_gpio;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_bus(input int b, input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
        if (b == 0) begin
            b0_req = req; b0_we = we; b0_addr = addr; b0_be = be; b0_wdata = wd;
        end else begin
            b1_req = req; b1_we = we; b1_addr = addr; b1_be = be; b1_wdata = wd;
        end
    endtask

    function automatic logic ack_of(input int b);
        return (b == 0) ? b0_ack : b1_ack;
    endfunction

    function automatic logic resp_of(input int b);
        return (b == 0) ? b0_resp : b1_resp;
    endfunction

    function automatic logic [31:0] rd_of(input int b);
        return (b == 0) ? b0_rdata : b1_rdata;
    endfunction

    // Present a request until acked, then wait for the read response.
    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_access(input int b, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             output logic [31:0] rd, output int lat);
        bit got;
        got = 0;
        rd  = 'x;
        lat = -1;
        set_bus(b, 1'b1, we, addr, be, wd);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk_i);
            if (ack_of(b)) got = 1;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        set_bus(b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        if (got && !we) begin
            for (int k = 1; k <= 10 && lat < 0; k++) begin
                @(negedge clk_i);
                if (resp_of(b)) begin
                    lat = k;
                    rd  = rd_of(b);
                end
            end
            @(posedge clk_i); #1;
        end
    endtask

    vec_t        vt[22];
    logic [31:0] rd;
    int          lat;
    logic        e_ack0[5], e_ack1[5], e_rsp0[5], e_rsp1[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // bus, we, addr, be, wdata, exp_rd, exp_lat, exp_gpio
        vt[0]  = '{0, 1'b0, 32'h8000000C, 4'hF, 32'h0,        32'hFFFFFFFF, IO_LAT, 32'h0};
        vt[1]  = '{0, 1'b0, 32'h80000010, 4'hF, 32'h0,        32'h00000000, IO_LAT, 32'h0};
        vt[2]  = '{0, 1'b1, 32'h80000000, 4'hF, 32'hDEADBEEF, 32'h0,        0,      32'hDEADBEEF};
        vt[3]  = '{1, 1'b1, 32'h80000000, 4'h1, 32'h00000011, 32'h0,        0,      32'hDEADBE11};
        vt[4]  = '{0, 1'b0, 32'h80000000, 4'hF, 32'h0,        32'hDEADBE11, IO_LAT, 32'hDEADBE11};
        vt[5]  = '{1, 1'b1, 32'h80000000, 4'hC, 32'h12340000, 32'h0,        0,      32'h1234BE11};
        vt[6]  = '{1, 1'b0, 32'h80000000, 4'hF, 32'h0,        32'h1234BE11, IO_LAT, 32'h1234BE11};
        vt[7]  = '{0, 1'b1, 32'h8000000C, 4'hF, 32'h00000005, 32'h0,        0,      32'h1234BE11};
        vt[8]  = '{1, 1'b0, 32'h8000000C, 4'hF, 32'h0,        32'h00000005, IO_LAT, 32'h1234BE11};
        vt[9]  = '{0, 1'b1, 32'h8000000C, 4'h2, 32'h0000AB00, 32'h0,        0,      32'h1234BE11};
        vt[10] = '{0, 1'b0, 32'h8000000C, 4'hF, 32'h0,        32'h0000AB05, IO_LAT, 32'h1234BE11};
        vt[11] = '{0, 1'b0, 32'h80000040, 4'hF, 32'h0,        32'h55AA55AA, IO_LAT, 32'h1234BE11};
        vt[12] = '{0, 1'b1, 32'h80000040, 4'hF, 32'hFFFFFFFF, 32'h0,        0,      32'h1234BE11};
        vt[13] = '{1, 1'b0, 32'h80000000, 4'hF, 32'h0,        32'h1234BE11, IO_LAT, 32'h1234BE11};
        vt[14] = '{1, 1'b0, 32'h8000000C, 4'hF, 32'h0,        32'h0000AB05, IO_LAT, 32'h1234BE11};
        vt[15] = '{0, 1'b0, 32'h80000004, 4'hF, 32'h0,        32'hA5A50F0F, IO_LAT, 32'h1234BE11};
        vt[16] = '{0, 1'b1, 32'h00000010, 4'hF, 32'hCAFEF00D, 32'h0,        0,      32'h1234BE11};
        vt[17] = '{0, 1'b0, 32'h00000010, 4'hF, 32'h0,        32'hCAFEF00D, 1,      32'h1234BE11};
        vt[18] = '{1, 1'b1, 32'h00000010, 4'h3, 32'h00001234, 32'h0,        0,      32'h1234BE11};
        vt[19] = '{1, 1'b0, 32'h00000010, 4'hF, 32'h0,        32'hCAFE1234, 1,      32'h1234BE11};
        vt[20] = '{0, 1'b0, 32'h00000010, 4'hF, 32'h0,        32'hCAFE1234, 1,      32'h1234BE11};
        vt[21] = '{1, 1'b1, 32'h80000000, 4'hF, 32'h000000A0, 32'h0,        0,      32'h000000A0};

        set_bus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        gpio_in = 32'hA5A50F0F;
        rst_i   = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_resp", {30'b0, b1_resp, b0_resp}, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Table-driven single accesses
        for (int i = 0; i < 22; i++) begin
            do_access(vt[i].bus, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, rd, lat);
            if (!vt[i].we) begin
                chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
                chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
            end
            chk($sformatf("v%0d_gpio", i), gpio_out, vt[i].exp_gpio);
        end

        // Both buses read MMIO every cycle; bus1 had the last grant.
        // Outstanding reads hold each bus off until its own resp cycle.
        e_ack0 = '{1, 0, 0, 1, 0};  e_ack1 = '{0, 1, 0, 0, 1};
        e_rsp0 = '{0, 0, 0, 1, 0};  e_rsp1 = '{0, 0, 0, 0, 1};
        set_bus(0, 1'b1, 1'b0, 32'h80000000, 4'hF, 32'h0);
        set_bus(1, 1'b1, 1'b0, 32'h80000000, 4'hF, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk($sformatf("arb_rd_ack0_c%0d", c), {31'b0, b0_ack}, {31'b0, e_ack0[c]});
            chk($sformatf("arb_rd_ack1_c%0d", c), {31'b0, b1_ack}, {31'b0, e_ack1[c]});
            chk($sformatf("arb_rd_rsp0_c%0d", c), {31'b0, b0_resp}, {31'b0, e_rsp0[c]});
            chk($sformatf("arb_rd_rsp1_c%0d", c), {31'b0, b1_resp}, {31'b0, e_rsp1[c]});
            if (b0_resp) chk("arb_rd_data0", b0_rdata, 32'h000000A0);
            @(posedge clk_i); #1;
        end
        set_bus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (5) @(posedge clk_i); #1;

        // Writes are never gated, so grants strictly alternate
        set_bus(0, 1'b1, 1'b1, 32'h80000000, 4'hF, 32'h11111111);
        set_bus(1, 1'b1, 1'b1, 32'h80000000, 4'hF, 32'h22222222);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk($sformatf("arb_wr_ack0_c%0d", c), {31'b0, b0_ack}, {31'b0, (c % 2 == 0)});
            chk($sformatf("arb_wr_ack1_c%0d", c), {31'b0, b1_ack}, {31'b0, (c % 2 == 1)});
            @(posedge clk_i); #1;
        end
        set_bus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_bus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("arb_wr_gpio", gpio_out, 32'h22222222);

        // Timer match: CMP = 20, TIMER = 10 -> irq 11 cycles after the load
        do_access(0, 1'b1, 32'h80000010, 4'h1, 32'h1, rd, lat);
        chk("tmr_pre_clr_irq", {31'b0, irq}, 32'h0);
        do_access(0, 1'b1, 32'h8000000C, 4'hF, 32'd20, rd, lat);
        do_access(1, 1'b1, 32'h80000008, 4'hF, 32'd10, rd, lat);
        chk("tmr_k0_irq", {31'b0, irq}, 32'h0);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk_i); #1;
            if (k == 10) chk("tmr_k10_irq", {31'b0, irq}, 32'h0);
            if (k == 11) chk("tmr_k11_irq", {31'b0, irq}, 32'h1);
        end
        do_access(0, 1'b0, 32'h80000010, 4'hF, 32'h0, rd, lat);
        chk("tmr_status_rd", rd, 32'h1);
        chk("tmr_sticky_irq", {31'b0, irq}, 32'h1);
        do_access(1, 1'b1, 32'h80000010, 4'h1, 32'h1, rd, lat);
        chk("tmr_clr_irq", {31'b0, irq}, 32'h0);

        // RAM read then MMIO read: the MMIO read is acked in the RAM resp cycle
        set_bus(0, 1'b1, 1'b0, 32'h00000010, 4'hF, 32'h0);
        @(negedge clk_i);
        chk("gate_a_ram_ack", {31'b0, b0_ack}, 32'h1);
        @(posedge clk_i); #1;
        set_bus(0, 1'b1, 1'b0, 32'h80000004, 4'hF, 32'h0);
        @(negedge clk_i);
        chk("gate_a_ram_resp", {31'b0, b0_resp}, 32'h1);
        chk("gate_a_ram_data", b0_rdata, 32'hCAFE1234);
        chk("gate_a_io_ack", {31'b0, b0_ack}, 32'h1);
        @(posedge clk_i); #1;
        set_bus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            chk($sformatf("gate_a_io_resp_%0d", c), {31'b0, b0_resp}, {31'b0, (c == 3)});
            if (c == 3) chk("gate_a_io_data", b0_rdata, 32'hA5A50F0F);
        end
        @(posedge clk_i); #1;

        // MMIO read then RAM read: the RAM read waits for the MMIO resp
        set_bus(0, 1'b1, 1'b0, 32'h80000000, 4'hF, 32'h0);
        @(negedge clk_i);
        chk("gate_b_io_ack", {31'b0, b0_ack}, 32'h1);
        @(posedge clk_i); #1;
        set_bus(0, 1'b1, 1'b0, 32'h00000010, 4'hF, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            chk($sformatf("gate_b_ram_ack_%0d", c), {31'b0, b0_ack}, {31'b0, (c == 3)});
            chk($sformatf("gate_b_io_resp_%0d", c), {31'b0, b0_resp}, {31'b0, (c == 3)});
            if (c == 3) chk("gate_b_io_data", b0_rdata, 32'h22222222);
            @(posedge clk_i); #1;
        end
        set_bus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk_i);
        chk("gate_b_ram_resp", {31'b0, b0_resp}, 32'h1);
        chk("gate_b_ram_data", b0_rdata, 32'hCAFE1234);
        @(posedge clk_i); #1;

        // Reset while an MMIO read is in flight: its resp must never appear
        set_bus(0, 1'b1, 1'b0, 32'h80000000, 4'hF, 32'h0);
        @(negedge clk_i);
        chk("rst_mid_ack", {31'b0, b0_ack}, 32'h1);
        @(posedge clk_i); #1;
        set_bus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            chk($sformatf("rst_mid_resp_%0d", c), {30'b0, b1_resp, b0_resp}, 32'h0);
        end
        chk("rst_mid_gpio", gpio_out, 32'h0);
        chk("rst_mid_irq", {31'b0, irq}, 32'h0);
        @(posedge clk_i); #1;
        do_access(1, 1'b0, 32'h8000000C, 4'hF, 32'h0, rd, lat);
        chk("rst_mid_cmp", rd, 32'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
